// File: rtl/a_add_serdrv.sv
// Clocked driver/collector for a bit-serial async adder cell: streams operand bits LSB first
// over two-phase bundled-data channels and assembles the returned sum and carry tokens.
module a_add_serdrv #(
    parameter logic        Rpol        = 1'b0,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             r_o,
    input  logic             a_o,
    output logic [1:0]       d_o,
    output logic             rc_o,
    input  logic             ac_o,
    output logic             dc_o,
    input  logic             r_s,
    output logic             a_s,
    input  logic             d_s,
    input  logic             r_c,
    output logic             a_c,
    input  logic             d_c,
    output logic             protocol_err
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {StIdle, StSetup, StSend, StWait, StDone} state_e;

    state_e state, state_nxt;

    logic [WIDTH-1:0]       a_q, b_q;
    logic                   carry_q;
    logic [IW-1:0]          idx_q;
    logic [3:0]             done_q;   // {carry token, sum token, carry-in ack, operand ack}
    logic [SYNC_STAGES-1:0] sync_q [4];
    logic [3:0]             async_in, synced;

    logic op_acked, c_acked, sum_tok, car_tok;
    logic take_sum, take_car, err_evt, all_done, last_bit;

    assign async_in = {r_c, r_s, ac_o, a_o};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) sync_q[k] <= {SYNC_STAGES{Rpol}};
        end else begin
            for (int k = 0; k < 4; k++) begin
                sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], async_in[k]};
            end
        end
    end

    always_comb begin
        synced = '0;
        for (int k = 0; k < 4; k++) synced[k] = sync_q[k][SYNC_STAGES-1];
    end

    assign op_acked = (synced[0] == r_o);
    assign c_acked  = (synced[1] == rc_o);
    assign sum_tok  = (synced[2] != a_s);
    assign car_tok  = (synced[3] != a_c);
    assign take_sum = (state == StWait) && sum_tok && !done_q[2];
    assign take_car = (state == StWait) && car_tok && !done_q[3];
    // Any pending incoming token not consumed this cycle is unexpected and stays unacked.
    assign err_evt  = (sum_tok && !take_sum) || (car_tok && !take_car);
    assign all_done = &done_q;
    assign last_bit = (idx_q == IW'(WIDTH - 1));
    assign op_ready = (state == StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= StIdle;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            StIdle:  if (op_valid) state_nxt = StSetup;
            StSetup: state_nxt = StSend;
            StSend:  state_nxt = StWait;
            StWait:  if (all_done) state_nxt = last_bit ? StDone : StSetup;
            StDone:  if (res_ready) state_nxt = StIdle;
            default: state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            done_q       <= '0;
            d_o          <= '0;
            dc_o         <= 1'b0;
            r_o          <= Rpol;
            rc_o         <= Rpol;
            a_s          <= Rpol;
            a_c          <= Rpol;
            res_sum      <= '0;
            res_cout     <= 1'b0;
            res_valid    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (err_evt) protocol_err <= 1'b1;
            if (take_sum) begin
                res_sum[idx_q] <= d_s;
                a_s            <= ~a_s;
            end
            if (take_car) begin
                carry_q <= d_c;
                a_c     <= ~a_c;
            end
            unique case (state)
                StIdle: begin
                    if (op_valid) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        carry_q <= op_cin;
                        idx_q   <= '0;
                    end
                end
                StSetup: begin
                    d_o  <= {a_q[idx_q], b_q[idx_q]};
                    dc_o <= carry_q;
                end
                StSend: begin
                    r_o    <= ~r_o;
                    rc_o   <= ~rc_o;
                    done_q <= '0;
                end
                StWait: begin
                    done_q <= done_q | {take_car, take_sum, c_acked, op_acked};
                    if (all_done) begin
                        done_q <= '0;
                        if (last_bit) begin
                            res_cout  <= carry_q;
                            res_valid <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                StDone: if (res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_a_add_serdrv.sv
// Bench for a_add_serdrv: two instances (Rpol 0 and 1), each driving a behavioural async adder
// with configurable token order and delays; results checked against plain integer addition.
module tb_a_add_serdrv;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] op_valid, op_ready, op_cin, res_valid, res_ready, res_cout;
    logic [1:0] r_o, a_o, rc_o, ac_o, dc_o, r_s, a_s, d_s, r_c, a_c, d_c, protocol_err;
    logic [1:0] inj, rev, rnd, pol;
    logic [7:0] op_a [2];
    logic [7:0] op_b [2];
    logic [7:0] res_sum [2];
    logic [1:0] d_o [2];

    int n_cmp = 0;
    int n_bad = 0;

    assign pol = 2'b10;

    always #5 clk = ~clk;

    a_add_serdrv #(.Rpol(1'b0), .WIDTH(8), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .op_valid(op_valid[0]), .op_ready(op_ready[0]), .op_a(op_a[0]),
        .op_b(op_b[0]), .op_cin(op_cin[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_sum(res_sum[0]), .res_cout(res_cout[0]), .r_o(r_o[0]), .a_o(a_o[0]), .d_o(d_o[0]),
        .rc_o(rc_o[0]), .ac_o(ac_o[0]), .dc_o(dc_o[0]), .r_s(r_s[0]), .a_s(a_s[0]), .d_s(d_s[0]),
        .r_c(r_c[0]), .a_c(a_c[0]), .d_c(d_c[0]), .protocol_err(protocol_err[0])
    );

    a_add_serdrv #(.Rpol(1'b1), .WIDTH(8), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .op_valid(op_valid[1]), .op_ready(op_ready[1]), .op_a(op_a[1]),
        .op_b(op_b[1]), .op_cin(op_cin[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_sum(res_sum[1]), .res_cout(res_cout[1]), .r_o(r_o[1]), .a_o(a_o[1]), .d_o(d_o[1]),
        .rc_o(rc_o[1]), .ac_o(ac_o[1]), .dc_o(dc_o[1]), .r_s(r_s[1]), .a_s(a_s[1]), .d_s(d_s[1]),
        .r_c(r_c[1]), .a_c(a_c[1]), .d_c(d_c[1]), .protocol_err(protocol_err[1])
    );

    // Behavioural adder cell: per bit, wait for both input tokens, emit outputs, then ack inputs.
    int unsigned st  [2];
    int unsigned dly [2];
    logic [1:0]  sv, cv;

    function automatic int unsigned pick(input logic r);
        return r ? $urandom_range(20, 1) : 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                a_o[g]  <= pol[g];
                ac_o[g] <= pol[g];
                r_s[g]  <= pol[g];
                r_c[g]  <= pol[g];
                d_s[g]  <= 1'b0;
                d_c[g]  <= 1'b0;
                st[g]   <= 0;
                dly[g]  <= 0;
            end else begin
                case (st[g])
                    0: begin
                        if (r_o[g] != a_o[g] && rc_o[g] != ac_o[g]) begin
                            sv[g]  <= d_o[g][1] ^ d_o[g][0] ^ dc_o[g];
                            cv[g]  <= (d_o[g][1] & d_o[g][0]) | (dc_o[g] & (d_o[g][1] ^ d_o[g][0]));
                            dly[g] <= pick(rnd[g]);
                            st[g]  <= 1;
                        end else if (inj[g]) begin
                            r_s[g] <= ~r_s[g];
                        end
                    end
                    1, 2: begin
                        if (dly[g] > 1) dly[g] <= dly[g] - 1;
                        else begin
                            if (rev[g] ^ (st[g] == 2)) begin
                                r_c[g] <= ~r_c[g];
                                d_c[g] <= cv[g];
                            end else begin
                                r_s[g] <= ~r_s[g];
                                d_s[g] <= sv[g];
                            end
                            dly[g] <= pick(rnd[g]);
                            st[g]  <= st[g] + 1;
                        end
                    end
                    3: begin
                        if (a_s[g] == r_s[g] && a_c[g] == r_c[g]) begin
                            dly[g] <= pick(rnd[g]);
                            st[g]  <= 4;
                        end
                    end
                    default: begin
                        if (dly[g] > 1) dly[g] <= dly[g] - 1;
                        else begin
                            if (rev[g] ^ (st[g] == 5)) ac_o[g] <= ~ac_o[g];
                            else                       a_o[g]  <= ~a_o[g];
                            dly[g] <= pick(rnd[g]);
                            st[g]  <= (st[g] == 5) ? 0 : 5;
                        end
                    end
                endcase
            end
        end
    end

    logic [1:0] r_prev, rc_prev;
    int cnt_r  [2] = '{0, 0};
    int cnt_rc [2] = '{0, 0};

    always @(posedge clk) begin
        r_prev  <= r_o;
        rc_prev <= rc_o;
        for (int g = 0; g < 2; g++) begin
            if (r_o[g] != r_prev[g])   cnt_r[g]  <= cnt_r[g] + 1;
            if (rc_o[g] != rc_prev[g]) cnt_rc[g] <= cnt_rc[g] + 1;
        end
    end

    // Called at a negedge with the instance idle; returns at the negedge where res_valid is seen.
    task automatic do_op(input int g, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         output logic [8:0] got, output int nr, output int nrc, output bit to);
        int n;
        int sr, src;
        sr = cnt_r[g];
        src = cnt_rc[g];
        op_a[g] = a;
        op_b[g] = b;
        op_cin[g] = cin;
        op_valid[g] = 1'b1;
        n = 0;
        while (!op_ready[g] && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        op_valid[g] = 1'b0;
        n = 0;
        while (!res_valid[g] && n < 4000) begin @(negedge clk); n++; end
        to  = !res_valid[g];
        got = {res_cout[g], res_sum[g]};
        nr  = cnt_r[g] - sr;
        nrc = cnt_rc[g] - src;
    endtask

    task automatic release_res(input int g);
        res_ready[g] = 1'b1;
        @(negedge clk);
        res_ready[g] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if ({r_o[g], rc_o[g], a_s[g], a_c[g]} !== {4{pol[g]}}) begin
                n_bad++;
                $display("FAIL reset_hs[%0d]: got %b want %b", g,
                         {r_o[g], rc_o[g], a_s[g], a_c[g]}, {4{pol[g]}});
            end
            n_cmp++;
            if ({d_o[g], dc_o[g], res_cout[g], res_valid[g], protocol_err[g], res_sum[g]} !== 14'd0
                || op_ready[g] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_out[%0d]: data %h ready %b want 0 / 1", g,
                         {d_o[g], dc_o[g], res_cout[g], res_valid[g], protocol_err[g], res_sum[g]},
                         op_ready[g]);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed(input logic [1:0] rv, input logic [1:0] rn);
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vc [3];
        logic [8:0] exp, got;
        int nr, nrc;
        bit to;
        va = '{8'h5A, 8'hFF, 8'h00};
        vb = '{8'h3C, 8'h01, 8'h00};
        vc = '{1'b0, 1'b0, 1'b1};
        rev = rv;
        rnd = rn;
        for (int g = 0; g < 2; g++) begin
            for (int v = 0; v < 3; v++) begin
                exp = {1'b0, va[v]} + {1'b0, vb[v]} + {8'd0, vc[v]};
                do_op(g, va[v], vb[v], vc[v], got, nr, nrc, to);
                n_cmp++;
                if (to || got !== exp) begin
                    n_bad++;
                    $display("FAIL dir_result[%0d] %h+%h+%b: got %h timeout %0d want %h", g,
                             va[v], vb[v], vc[v], got, to, exp);
                end
                n_cmp++;
                if (nr != 8 || nrc != 8 || protocol_err[g] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL dir_toggles[%0d]: r_o %0d rc_o %0d err %b want 8 8 0", g,
                             nr, nrc, protocol_err[g]);
                end
                release_res(g);
                n_cmp++;
                if ({r_o[g], rc_o[g], a_o[g], ac_o[g], r_s[g], a_s[g], r_c[g], a_c[g]}
                    !== {8{pol[g]}}) begin
                    n_bad++;
                    $display("FAIL dir_idle_wires[%0d]: got %b want all %b", g,
                             {r_o[g], rc_o[g], a_o[g], ac_o[g], r_s[g], a_s[g], r_c[g], a_c[g]},
                             pol[g]);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] a, b;
        logic       c;
        logic [8:0] exp, got;
        int nr, nrc, g;
        bit to;
        rnd = 2'b11;
        for (int k = 0; k < 12; k++) begin
            g = k % 2;
            rev[g] = $urandom_range(1, 0);
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
            do_op(g, a, b, c, got, nr, nrc, to);
            n_cmp++;
            if (to || got !== exp || nr != 8 || protocol_err[g] !== 1'b0) begin
                n_bad++;
                $display("FAIL rand[%0d] %h+%h+%b rev %b: got %h toggles %0d err %b want %h 8 0",
                         g, a, b, c, rev[g], got, nr, protocol_err[g], exp);
            end
            release_res(g);
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] exp, exp2, got;
        int nr, nrc, n;
        bit to;
        rev = 2'b00;
        rnd = 2'b00;
        exp = 9'h0A7 + 9'h0C3 + 9'd1;
        do_op(0, 8'hA7, 8'hC3, 1'b1, got, nr, nrc, to);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (res_valid[0] !== 1'b1 || {res_cout[0], res_sum[0]} !== exp
                || op_ready[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL hold cycle %0d: valid %b result %h ready %b want 1 %h 0", k,
                         res_valid[0], {res_cout[0], res_sum[0]}, op_ready[0], exp);
            end
        end
        // Offer the next operand in the same cycle the result is consumed.
        exp2 = 9'h012 + 9'h0EE + 9'd0;
        op_a[0] = 8'h12;
        op_b[0] = 8'hEE;
        op_cin[0] = 1'b0;
        op_valid[0] = 1'b1;
        res_ready[0] = 1'b1;
        @(negedge clk);
        res_ready[0] = 1'b0;
        n_cmp++;
        if (res_valid[0] !== 1'b0 || op_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL release: valid %b ready %b want 0 1", res_valid[0], op_ready[0]);
        end
        @(negedge clk);
        op_valid[0] = 1'b0;
        n = 0;
        while (!res_valid[0] && n < 4000) begin @(negedge clk); n++; end
        n_cmp++;
        if (res_valid[0] !== 1'b1 || {res_cout[0], res_sum[0]} !== exp2) begin
            n_bad++;
            $display("FAIL back_to_back: valid %b result %h want 1 %h", res_valid[0],
                     {res_cout[0], res_sum[0]}, exp2);
        end
        release_res(0);
    endtask

    task automatic test_reset_mid_wait;
        int sr, n;
        rev = 2'b00;
        rnd = 2'b01;
        sr = cnt_r[0];
        op_a[0] = 8'h77;
        op_b[0] = 8'h99;
        op_cin[0] = 1'b1;
        op_valid[0] = 1'b1;
        @(negedge clk);
        op_valid[0] = 1'b0;
        n = 0;
        while (cnt_r[0] - sr < 4 && n < 3000) begin @(negedge clk); n++; end
        n_cmp++;
        if (cnt_r[0] - sr != 4) begin
            n_bad++;
            $display("FAIL mid_wait_reach: r_o toggles %0d want 4", cnt_r[0] - sr);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({r_o[0], rc_o[0], a_s[0], a_c[0]} !== 4'b0000
            || {d_o[0], dc_o[0], res_cout[0], res_valid[0], protocol_err[0], res_sum[0]} !== 14'd0
            || op_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_wait_reset: hs %b data %h ready %b want 0000 0 1",
                     {r_o[0], rc_o[0], a_s[0], a_c[0]},
                     {d_o[0], dc_o[0], res_cout[0], res_valid[0], protocol_err[0], res_sum[0]},
                     op_ready[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_spurious;
        inj[0] = 1'b1;
        @(negedge clk);
        inj[0] = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (protocol_err[0] !== 1'b1 || a_s[0] !== 1'b0 || protocol_err[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL spurious: err %b a_s %b other err %b want 1 0 0", protocol_err[0],
                     a_s[0], protocol_err[1]);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (protocol_err[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b want 1", protocol_err[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (protocol_err[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: got %b want 0", protocol_err[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        op_valid = '0;
        op_cin = '0;
        res_ready = '0;
        inj = '0;
        rev = '0;
        rnd = '0;
        op_a = '{8'd0, 8'd0};
        op_b = '{8'd0, 8'd0};
        repeat (2) @(negedge clk);
        test_reset;
        test_directed(2'b00, 2'b00);
        test_directed(2'b11, 2'b11);
        test_random;
        test_back_to_back;
        test_reset_mid_wait;
        test_directed(2'b00, 2'b00);
        test_spurious;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
